// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: display read port, renderer write port, swap control and SRAM side.
// stall_cycles exists only when SRAM_ARB_STATS_EN is defined.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              disp_read;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_last;
  logic [31:0]       disp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              render_done;
  logic              swap_done;
  logic              front_sel;
  logic              sram_read;
  logic              sram_we;
  logic [ADDR_W:0]   sram_addr;
  logic [31:0]       sram_wdata;
  logic [3:0]        sram_be;
  logic [31:0]       sram_rdata;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]       stall_cycles;
`endif

  modport slave (
    input  disp_read, disp_addr, disp_last, wr_valid, wr_addr, wr_data, wr_be,
           render_done, sram_rdata,
`ifdef SRAM_ARB_STATS_EN
    output stall_cycles,
`endif
    output disp_data, wr_ready, swap_done, front_sel, sram_read, sram_we, sram_addr,
           sram_wdata, sram_be
  );

  modport master (
    output disp_read, disp_addr, disp_last, wr_valid, wr_addr, wr_data, wr_be,
           render_done, sram_rdata,
`ifdef SRAM_ARB_STATS_EN
    input  stall_cycles,
`endif
    input  disp_data, wr_ready, swap_done, front_sel, sram_read, sram_we, sram_addr,
           sram_wdata, sram_be
  );
endinterface

// File: rtl/sram_arbiter.sv
// Double-buffered SRAM arbiter: display reads take priority, renderer writes are queued and
// drained into the back buffer; buffers swap on a frame boundary. Optional SRAM_ARB_STATS_EN.
module sram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RENDER     = 2'd0,
    DRAIN      = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_front_sel;
  logic   r_swap_done;

  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [31:0]       r_mem_data [FIFO_DEPTH];
  logic [3:0]        r_mem_be   [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;

  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_swap;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_ready = !rst && (r_state == RENDER) && !w_full;
  assign w_push  = bus.wr_valid && w_ready;
  assign w_pop   = !rst && !bus.disp_read && !w_empty;
  assign w_swap  = (r_state == WAIT_FRAME) && bus.disp_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr[PTR_W-1:0]] <= bus.wr_addr;
      r_mem_data[r_wptr[PTR_W-1:0]] <= bus.wr_data;
      r_mem_be[r_wptr[PTR_W-1:0]]   <= bus.wr_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RENDER;
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_swap_done <= w_swap;
      if (w_swap) r_front_sel <= ~r_front_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RENDER:     if (bus.render_done) w_state_nxt = DRAIN;
      DRAIN:      if (w_empty)         w_state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (bus.disp_last)   w_state_nxt = RENDER;
      default:                         w_state_nxt = RENDER;
    endcase
  end

  always_comb begin
    bus.sram_read  = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.sram_be    = '0;
    if (bus.disp_read) begin
      bus.sram_read = 1'b1;
      bus.sram_addr = {r_front_sel, bus.disp_addr};
    end else if (w_pop) begin
      bus.sram_we    = 1'b1;
      bus.sram_addr  = {~r_front_sel, r_mem_addr[r_rptr[PTR_W-1:0]]};
      bus.sram_wdata = r_mem_data[r_rptr[PTR_W-1:0]];
      bus.sram_be    = r_mem_be[r_rptr[PTR_W-1:0]];
    end
  end

  assign bus.disp_data = bus.sram_rdata;
  assign bus.wr_ready  = w_ready;
  assign bus.swap_done = r_swap_done;
  assign bus.front_sel = r_front_sel;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_swap) begin
      r_stall_cnt <= '0;
    end else if (bus.wr_valid && !w_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cnt;
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a queue-based model of the arbitration and swap rules.
module tb_sram_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 19;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) bus ();

  sram_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  wr_t q[$];
  int  phase;     // 0 render, 1 drain, 2 wait for frame
  bit  m_front;
  bit  m_swap;
  int  m_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // Called just after a falling edge with inputs settled; returns at the next falling edge.
  task automatic run_cycle();
    logic          er, ew, erdy;
    logic [AW:0]   ea;
    logic [31:0]   ed;
    logic [3:0]    eb;
    bit            was_empty, do_pop, do_push, sw;
    wr_t           e;
    #1;
    if (rst) begin
      q.delete();
      phase = 0; m_front = 0; m_swap = 0; m_stall = 0;
    end
    erdy = !rst && (phase == 0) && (q.size() < DEPTH);
    er = 0; ew = 0; ea = '0; ed = '0; eb = '0;
    if (bus.disp_read) begin
      er = 1;
      ea = {m_front, bus.disp_addr};
    end else if (q.size() > 0) begin
      ew = 1;
      ea = {~m_front, q[0].a};
      ed = q[0].d;
      eb = q[0].be;
    end
    chk("wr_ready",   64'(bus.wr_ready),   64'(erdy));
    chk("sram_read",  64'(bus.sram_read),  64'(er));
    chk("sram_we",    64'(bus.sram_we),    64'(ew));
    chk("sram_addr",  64'(bus.sram_addr),  64'(ea));
    chk("sram_wdata", 64'(bus.sram_wdata), 64'(ed));
    chk("sram_be",    64'(bus.sram_be),    64'(eb));
    chk("disp_data",  64'(bus.disp_data),  64'(bus.sram_rdata));
    chk("front_sel",  64'(bus.front_sel),  64'(m_front));
    chk("swap_done",  64'(bus.swap_done),  64'(m_swap));
`ifdef SRAM_ARB_STATS_EN
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
`endif
    if (!rst) begin
      was_empty = (q.size() == 0);
      do_pop    = !bus.disp_read && !was_empty;
      do_push   = bus.wr_valid && erdy;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.a = bus.wr_addr; e.d = bus.wr_data; e.be = bus.wr_be;
        q.push_back(e);
      end
      sw = 0;
      case (phase)
        0: if (bus.render_done) phase = 1;
        1: if (was_empty) phase = 2;
        default: if (bus.disp_last) begin phase = 0; sw = 1; end
      endcase
      if (sw) m_stall = 0;
      else if (bus.wr_valid && !erdy && m_stall < 65535) m_stall++;
      if (sw) m_front = ~m_front;
      m_swap = sw;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.disp_read = 0; bus.disp_addr = '0; bus.disp_last = 0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.render_done = 0; bus.sram_rdata = '0;
  endtask

  initial begin
    int unsigned p_read;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    run_cycle();
    rst = 0;

    // Display read passes straight through with the front-buffer index.
    bus.disp_read = 1; bus.disp_addr = 19'h00010; bus.sram_rdata = 32'hDEADBEEF;
    run_cycle();

    // Fill the queue while reads block it, then let it drain.
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1; bus.wr_addr = 19'(i); bus.wr_data = 32'hA000_0000 + 32'(i);
      bus.wr_be = 4'hF;
      run_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) run_cycle();

    // Frame boundary during drain must not swap; queue two writes, then finish render.
    for (int i = 0; i < 2; i++) begin
      bus.disp_read = 1; bus.wr_valid = 1; bus.wr_addr = 19'(16 + i); bus.wr_data = $urandom;
      bus.wr_be = 4'(i + 3);
      run_cycle();
    end
    bus.wr_valid = 0; bus.render_done = 1; run_cycle();
    bus.render_done = 0; bus.disp_last = 1; run_cycle();
    bus.disp_last = 0; bus.disp_read = 0;
    for (int i = 0; i < 4; i++) run_cycle();
    bus.disp_last = 1; run_cycle();
    bus.disp_last = 0; run_cycle();
    bus.wr_valid = 1; bus.wr_addr = 19'h7; run_cycle();
    bus.wr_valid = 0; run_cycle();

    // Randomized traffic at varying display-read pressure, with occasional resets.
    for (int seg = 0; seg < 6; seg++) begin
      case (seg)
        0: p_read = 10;
        1: p_read = 50;
        2: p_read = 90;
        3: p_read = 100;
        4: p_read = 30;
        default: p_read = 70;
      endcase
      for (int c = 0; c < 500; c++) begin
        rst             = ($urandom_range(0, 299) == 0);
        bus.disp_read   = ($urandom_range(0, 99) < p_read);
        bus.disp_addr   = AW'($urandom);
        bus.disp_last   = ($urandom_range(0, 11) == 0);
        bus.wr_valid    = ($urandom_range(0, 9) < 7);
        bus.wr_addr     = AW'($urandom);
        bus.wr_data     = $urandom;
        bus.wr_be       = 4'($urandom);
        bus.render_done = ($urandom_range(0, 24) == 0);
        bus.sram_rdata  = $urandom;
        run_cycle();
      end
    end
    rst = 0;
    idle_inputs();
    run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
